// File: rtl/ooo_master_reorder_if.sv
// Host-side request/response and out-of-order bus signals of the reorder bridge.
// The master modport is the bridge's view; slave is the view of the host plus the bus slave.
interface ooo_master_reorder_if #(
  parameter int TID_W = 2
);
  logic             host_req;
  logic             host_cmd;
  logic [31:0]      host_addr;
  logic [31:0]      host_wdata;
  logic             host_ack;
  logic             host_resp;
  logic [31:0]      host_rdata;
  logic             bus_req;
  logic             bus_cmd;
  logic [31:0]      bus_addr;
  logic [31:0]      bus_wdata;
  logic             bus_ack;
  logic [TID_W-1:0] bus_reqtid;
  logic             bus_resp;
  logic [TID_W-1:0] bus_resptid;
  logic [31:0]      bus_rdata;

  modport master (
    input  host_req, host_cmd, host_addr, host_wdata,
    output host_ack, host_resp, host_rdata,
    output bus_req, bus_cmd, bus_addr, bus_wdata,
    input  bus_ack, bus_reqtid, bus_resp, bus_resptid, bus_rdata
  );

  modport slave (
    output host_req, host_cmd, host_addr, host_wdata,
    input  host_ack, host_resp, host_rdata,
    input  bus_req, bus_cmd, bus_addr, bus_wdata,
    output bus_ack, bus_reqtid, bus_resp, bus_resptid, bus_rdata
  );
endinterface

// File: rtl/ooo_master_reorder.sv
// In-order host to tid-tagged out-of-order bus bridge; a slot ROB returns read data in issue order.
// Latency: bus_resp in cycle N -> host_resp in N+2 (N+1 for a head response when OOO_MASTER_BYPASS_EN).
// Backpressure: reads stall (bus_req=0) while the ROB is full; writes always pass; drain has no host stall.
module ooo_master_reorder #(
  parameter int ROB_DEPTH = 4,
  parameter int TID_W     = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  ooo_master_reorder_if.master         bus_if,
  output logic                         err_o,
  output logic [$clog2(ROB_DEPTH):0]   outstanding_o
);
  localparam int PW = $clog2(ROB_DEPTH);
  localparam int CW = PW + 1;

  // Slot storage: pending = waiting for the bus, filled = data ready to drain.
  logic [TID_W-1:0]     tid_q  [ROB_DEPTH];
  logic [31:0]          data_q [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] pend_q, fill_q;
  logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 resp_q, resp_d;
  logic [31:0]          rdata_q, rdata_d;

  logic                 rob_full, blk, alloc, rsp_hit, dup_err, drain, bypass, pop;
  logic [ROB_DEPTH-1:0] rsp_match, dup_match;

  // Fullness comes from the registered count, so a drain cannot unblock the same cycle.
  assign rob_full       = (cnt_q == CW'(ROB_DEPTH));
  assign blk            = !bus_if.host_cmd && rob_full;
  assign bus_if.bus_req   = bus_if.host_req && !blk;
  assign bus_if.bus_cmd   = bus_if.host_cmd;
  assign bus_if.bus_addr  = bus_if.host_addr;
  assign bus_if.bus_wdata = bus_if.host_wdata;
  assign bus_if.host_ack  = bus_if.bus_req && bus_if.bus_ack;
  assign alloc            = bus_if.host_ack && !bus_if.host_cmd;

  // Tid CAM over pre-edge pending slots for the response and for duplicate detection.
  always_comb begin
    rsp_match = '0;
    dup_match = '0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      rsp_match[i] = bus_if.bus_resp && pend_q[i] && (tid_q[i] == bus_if.bus_resptid);
      dup_match[i] = pend_q[i] && (tid_q[i] == bus_if.bus_reqtid);
    end
  end

  assign rsp_hit = |rsp_match;
  // A pending tid retired by this cycle's response may be legally reissued.
  assign dup_err = alloc && |(dup_match & ~rsp_match);
  assign drain   = fill_q[head_q];
`ifdef OOO_MASTER_BYPASS_EN
  // Head response goes straight to the host; head unfilled implies no drain this edge.
  assign bypass  = rsp_match[head_q] && !fill_q[head_q];
`else
  assign bypass  = 1'b0;
`endif
  assign pop     = drain || bypass;

  // Next-state for pointers, occupancy, error flag and host response registers.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    err_d   = err_q || (bus_if.bus_resp && !rsp_hit) || dup_err;
    resp_d  = 1'b0;
    rdata_d = rdata_q;
    if (drain) begin
      resp_d  = 1'b1;
      rdata_d = data_q[head_q];
    end else if (bypass) begin
      resp_d  = 1'b1;
      rdata_d = bus_if.bus_rdata;
    end
    if (pop)   head_d = head_q + PW'(1);
    if (alloc) tail_d = tail_q + PW'(1);
    cnt_d = cnt_q + {{PW{1'b0}}, alloc} - {{PW{1'b0}}, pop};
  end

  // Control registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  // Slot updates: fill on response, free on drain/bypass, allocate at tail.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q <= '0;
      fill_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        tid_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (rsp_match[i]) begin
          pend_q[i] <= 1'b0;
          data_q[i] <= bus_if.bus_rdata;
          if (!(bypass && (PW'(i) == head_q))) fill_q[i] <= 1'b1;
        end
        if (drain && (PW'(i) == head_q)) fill_q[i] <= 1'b0;
        if (alloc && (PW'(i) == tail_q)) begin
          pend_q[i] <= 1'b1;
          fill_q[i] <= 1'b0;
          tid_q[i]  <= bus_if.bus_reqtid;
        end
      end
    end
  end

  assign bus_if.host_resp  = resp_q;
  assign bus_if.host_rdata = rdata_q;
  assign err_o             = err_q;
  assign outstanding_o     = cnt_q;
endmodule

// File: tb/tb_ooo_master_reorder.sv
// Bench for ooo_master_reorder: directed test-plan scenarios plus a random out-of-order slave,
// all checked each cycle against an issue-order queue model of the bridge.
module tb_ooo_master_reorder;
  localparam int DEPTH = 4;
`ifdef OOO_MASTER_BYPASS_EN
  localparam int LAT   = 1;
`else
  localparam int LAT   = 2;
`endif

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       err_o;
  logic [2:0] outstanding_o;

  int checks   = 0;
  int failures = 0;

  ooo_master_reorder_if #(.TID_W(2)) bif ();

  ooo_master_reorder #(.ROB_DEPTH(DEPTH), .TID_W(2)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .bus_if        (bif),
    .err_o         (err_o),
    .outstanding_o (outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model: reads in issue order ----------------
  logic [1:0]  q_tid [$];
  logic [31:0] q_dat [$];
  bit          q_fil [$];
  bit          m_resp, m_err, m_drain, m_byp, e_req, e_ack;
  logic [31:0] m_rdata;
  int          mk;

  always @(negedge clk_i) begin
    if (rst_i) begin
      q_tid.delete(); q_dat.delete(); q_fil.delete();
      m_resp = 1'b0; m_rdata = '0; m_err = 1'b0;
    end
    chk("host_resp", bif.host_resp, m_resp);
    chk("host_rdata", bif.host_rdata, m_rdata);
    chk("err_o", err_o, m_err);
    chk("outstanding_o", outstanding_o, q_tid.size());
    if (!rst_i) begin
      e_req = bif.host_req && !(!bif.host_cmd && q_tid.size() == DEPTH);
      e_ack = e_req && bif.bus_ack;
      chk("bus_req", bif.bus_req, e_req);
      chk("host_ack", bif.host_ack, e_ack);
      chk("bus_cmd", bif.bus_cmd, bif.host_cmd);
      chk("bus_addr", bif.bus_addr, bif.host_addr);
      chk("bus_wdata", bif.bus_wdata, bif.host_wdata);
      // advance to the state after the coming edge
      m_drain = (q_tid.size() > 0) && q_fil[0];
      m_byp   = 1'b0;
      mk      = -1;
      if (bif.bus_resp) begin
        for (int i = 0; i < q_tid.size(); i++)
          if (!q_fil[i] && q_tid[i] == bif.bus_resptid) mk = i;
        if (mk < 0) m_err = 1'b1;
      end
      if (e_ack && !bif.host_cmd)
        for (int i = 0; i < q_tid.size(); i++)
          if (!q_fil[i] && q_tid[i] == bif.bus_reqtid && i != mk) m_err = 1'b1;
`ifdef OOO_MASTER_BYPASS_EN
      if (mk == 0) m_byp = 1'b1;
`endif
      if (mk >= 0 && !m_byp) begin
        q_fil[mk] = 1'b1;
        q_dat[mk] = bif.bus_rdata;
      end
      if (m_drain) begin
        m_resp = 1'b1; m_rdata = q_dat[0];
        void'(q_tid.pop_front()); void'(q_dat.pop_front()); void'(q_fil.pop_front());
      end else if (m_byp) begin
        m_resp = 1'b1; m_rdata = bif.bus_rdata;
        void'(q_tid.pop_front()); void'(q_dat.pop_front()); void'(q_fil.pop_front());
      end else begin
        m_resp = 1'b0;
      end
      if (e_ack && !bif.host_cmd) begin
        q_tid.push_back(bif.bus_reqtid); q_dat.push_back('0); q_fil.push_back(1'b0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic idle();
    bif.host_req = 0; bif.host_cmd = 0; bif.host_addr = '0; bif.host_wdata = '0;
    bif.bus_ack = 0; bif.bus_reqtid = '0; bif.bus_resp = 0; bif.bus_resptid = '0; bif.bus_rdata = '0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [1:0] t);
    bif.host_req = 1; bif.host_cmd = 0; bif.host_addr = a; bif.bus_ack = 1; bif.bus_reqtid = t;
  endtask

  task automatic rsp(input logic [1:0] t, input logic [31:0] d);
    bif.bus_resp = 1; bif.bus_resptid = t; bif.bus_rdata = d;
  endtask

  logic [1:0]  ord_tid [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
  logic [31:0] ord_dat [4] = '{32'hD, 32'hB, 32'hC, 32'hA};
  logic [1:0]  drn_tid [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
  logic [31:0] rec_d [4];
  int          rec_c [4];
  logic [1:0]  sq [$];
  logic [1:0]  free_t [4];
  int          lat, n, nrec, cnt, j, nfree;
  bit          got, busy;

  initial begin
    idle();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_host_resp", bif.host_resp, 0);
    chk("rst_host_rdata", bif.host_rdata, 0);
    chk("rst_err", err_o, 0);
    chk("rst_outstanding", outstanding_o, 0);
    rst_i = 0;

    // single in-order read
    cyc(); idle(); rd(32'h10, 2'd0);
    cyc(); idle();
    cyc(); cyc();
    rsp(2'd0, 32'hA5A5A5A5);
    lat = 0; got = 0;
    while (!got && lat < 6) begin
      cyc(); lat++;
      if (bif.host_resp) got = 1;
      idle();
    end
    chk("single_latency", lat, LAT);
    chk("single_data", bif.host_rdata, 32'hA5A5A5A5);

    // reorder: responses 3,1,2,0 must come back A,B,C,D back to back
    repeat (3) cyc();
    for (int i = 0; i < 4; i++) begin
      cyc(); idle(); rd(32'h100 + 32'(i) * 4, 2'(i));
    end
    nrec = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (bif.host_resp && nrec < 4) begin rec_d[nrec] = bif.host_rdata; rec_c[nrec] = c; nrec++; end
      idle();
      if (c < 4) rsp(ord_tid[c], ord_dat[c]);
    end
    chk("reorder_count", nrec, 4);
    chk("reorder_first_cycle", rec_c[0], 3 + LAT);
    for (int k = 0; k < 4; k++) begin
      chk("reorder_data", rec_d[k], 32'hA + 32'(k));
      chk("reorder_cycle", rec_c[k], rec_c[0] + k);
    end

    // full ROB: reads stall, writes pass, read unblocks after head drains
    for (int i = 0; i < 4; i++) begin
      cyc(); idle(); rd(32'h200 + 32'(i) * 4, 2'(i));
    end
    cyc(); idle(); rd(32'h300, 2'd0); #1;
    chk("full_bus_req", bif.bus_req, 0);
    chk("full_host_ack", bif.host_ack, 0);
    chk("full_outstanding", outstanding_o, 4);
    bif.host_cmd = 1; bif.host_wdata = 32'hCAFE; #1;
    chk("full_write_ack", bif.host_ack, 1);
    cyc(); idle(); rd(32'h300, 2'd0); rsp(2'd0, 32'h1000);
    n = 0; #1;
    while (!bif.host_ack && n < 6) begin
      cyc(); idle(); rd(32'h300, 2'd0); n++; #1;
    end
    chk("full_unblock", n, LAT);
    cyc(); idle();
    for (int i = 0; i < 4; i++) begin
      rsp(drn_tid[i], 32'h2000 + 32'(i)); cyc(); idle();
    end
    repeat (5) cyc();
    chk("full_drained", outstanding_o, 0);

    // same-cycle tid reuse
    nrec = 0;
    for (int c = 0; c < 10; c++) begin
      cyc();
      if (bif.host_resp && nrec < 4) begin rec_d[nrec] = bif.host_rdata; rec_c[nrec] = c; nrec++; end
      idle();
      case (c)
        0: rd(32'h400, 2'd1);
        1: begin rd(32'h404, 2'd1); rsp(2'd1, 32'h11); end
        4: rsp(2'd1, 32'h22);
        default: ;
      endcase
    end
    chk("reuse_count", nrec, 2);
    chk("reuse_first", rec_d[0], 32'h11);
    chk("reuse_second", rec_d[1], 32'h22);
    chk("reuse_err", err_o, 0);

    // random out-of-order slave
    sq.delete();
    for (int cy = 0; cy < 3000; cy++) begin
      cyc(); idle();
      if (sq.size() > 0 && $urandom_range(0, 2) != 0) begin
        j = $urandom_range(0, sq.size() - 1);
        rsp(sq[j], $urandom);
        sq.delete(j);
      end
      bif.host_req   = ($urandom_range(0, 3) != 0);
      bif.host_cmd   = ($urandom_range(0, 3) == 0);
      bif.host_addr  = $urandom;
      bif.host_wdata = $urandom;
      nfree = 0;
      for (int t = 0; t < 4; t++) begin
        busy = 0;
        foreach (sq[s]) if (sq[s] == 2'(t)) busy = 1;
        if (!busy) begin free_t[nfree] = 2'(t); nfree++; end
      end
      bif.bus_ack = ($urandom_range(0, 3) != 0);
      if (nfree > 0) bif.bus_reqtid = free_t[$urandom_range(0, nfree - 1)];
      else begin
        bif.bus_reqtid = 2'($urandom);
        if (!bif.host_cmd) bif.bus_ack = 0;
      end
      #1;
      if (bif.host_ack && !bif.host_cmd) sq.push_back(bif.bus_reqtid);
    end
    cnt = 0;
    cyc(); idle();
    while ((sq.size() > 0 || outstanding_o != 0) && cnt < 200) begin
      if (sq.size() > 0) begin rsp(sq[0], $urandom); void'(sq.pop_front()); end
      cyc(); idle(); cnt++;
    end
    chk("random_drained", outstanding_o, 0);
    chk("random_no_err", err_o, 0);

    // unmatched response sets sticky error
    rsp(2'd2, 32'hDEAD);
    cyc(); idle();
    chk("err_set", err_o, 1);
    repeat (3) cyc();
    chk("err_sticky", err_o, 1);

    // asynchronous reset mid-burst
    cyc(); idle(); rd(32'h500, 2'd0);
    cyc(); idle(); rd(32'h504, 2'd1); rsp(2'd0, 32'h55);
    cyc(); idle(); rd(32'h508, 2'd2);
    #2; rst_i = 1; #1;
    chk("arst_host_resp", bif.host_resp, 0);
    chk("arst_host_rdata", bif.host_rdata, 0);
    chk("arst_outstanding", outstanding_o, 0);
    chk("arst_err", err_o, 0);
    cyc(); idle(); cyc();
    rst_i = 0;
    cyc(); cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ooo_master_reorder.md
Name: ooo_master_reorder

Overview:
- Initiator-side bridge for the tid-tagged out-of-order memory bus; the slave returns read data in any order, tagged by `resptid`.
- Takes in-order host requests and drives them onto the bus. Tracks outstanding reads in a slot-based reorder buffer (ROB).
- Returns read data to the host strictly in issue order.
- Sits between a core/LSU-style in-order master and any out-of-order slave on the ariele test fabric.

Parameters:
- ROB_DEPTH, 4, max outstanding reads tracked; power of 2, >=2. May exceed the tid count because tids are reused.
- TID_W, 2, width of bus tid fields.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- host_req  in  1  host request valid
- host_cmd  in  1  0=read, 1=write
- host_addr  in  32  byte address
- host_wdata  in  32  write data
- host_ack  out  1  host request accepted this cycle
- host_resp  out  1  read data valid (registered)
- host_rdata  out  32  read data (registered)
- bus_req  out  1  bus request
- bus_cmd  out  1  passthrough of host_cmd
- bus_addr  out  32  passthrough of host_addr
- bus_wdata  out  32  passthrough of host_wdata
- bus_ack  in  1  slave accept
- bus_reqtid  in  TID_W  tid assigned by slave to an accepted read, valid in the same cycle
- bus_resp  in  1  slave read response valid
- bus_resptid  in  TID_W  tid of response
- bus_rdata  in  32  response data
- err_o  out  1  sticky protocol error
- outstanding_o  out  $clog2(ROB_DEPTH)+1  occupied ROB slots (registered)

Behaviour:
- Reset (async, rst_i=1):
  - All ROB slots are freed; head and tail pointers are 0.
  - host_resp=0, host_rdata=0, err_o=0, outstanding_o=0.
  - Data from in-flight responses is discarded.
- Issue path (combinational):
  - blk = !host_cmd & rob_full.
  - bus_req = host_req & !blk.
  - host_ack = bus_req & bus_ack.
- Writes:
  - Accepted on host_ack; no ROB slot is allocated and no host_resp is produced.
  - Writes carry no ordering guarantee versus outstanding reads.
- Read accept (host_ack & !host_cmd):
  - Allocate the slot at the tail: tid=bus_reqtid, pending=1, filled=0.
  - Advance tail (mod ROB_DEPTH).
- Response (bus_resp):
  - CAM on the pre-edge state: find the unique slot with pending=1 and tid==bus_resptid.
  - Write bus_rdata into that slot; set filled=1, pending=0.
  - If no slot matches, set err_o.
- Tid reuse: the slave may reissue a tid in the same cycle it returns a response for that tid.
  - The CAM uses only pre-edge state, so the response fills the old slot and the new read allocates a fresh pending slot.
  - Both happen at the same edge.
- Duplicate tid: a read accepted with bus_reqtid equal to a tid that is pending pre-edge sets err_o; the slot is still allocated.
- Drain:
  - At each edge, if head slot occupied & filled: host_resp<=1, host_rdata<=slot data, free the slot, advance head.
  - Otherwise host_resp<=0 and host_rdata holds its value.
  - At most one drain per cycle.
- Latency (without bypass): bus_resp in cycle N to host_resp in cycle N+2 (fill at edge N, drain at edge N+1).
- Full/empty:
  - rob_full when occupancy==ROB_DEPTH; reads stall (bus_req=0) while writes still pass.
  - A drain at the same edge does NOT unblock the current cycle (full is registered).
  - Alloc and drain at the same edge leave occupancy unchanged.
- Pointers wrap mod ROB_DEPTH. outstanding_o = occupancy after the edge.
- err_o clears only on reset.

Optional Feature:
- Macro: OOO_MASTER_BYPASS_EN.
- When defined, head bypass applies if all of these hold pre-edge:
  - bus_resp matches the head slot;
  - the head slot is not yet filled;
  - nothing else is draining.
- Bypass action: at that same edge, host_rdata<=bus_rdata and host_resp<=1, and the slot is freed without being filled. Head latency becomes N+1.
- When undefined, all responses go through the ROB (latency N+2).
- Ordering and err_o behaviour are identical in both builds.

Test Plan:
- In-order single read: issue read to 0x10, slave gives tid 0, responds 0xA5A5A5A5 tid 0 at cycle 5 -> host_resp=1 with 0xA5A5A5A5 at cycle 7 (cycle 6 with OOO_MASTER_BYPASS_EN).
- Reorder: reads A,B,C,D get tids 0..3; slave responds with data tagged by tid in order 3,1,2,0 with 0xD,0xB,0xC,0xA -> host_rdata sequence exactly 0xA,0xB,0xC,0xD on 4 consecutive cycles after the tid-0 response is stored.
- Full: ROB_DEPTH=4, 4 reads outstanding, host issues 5th read -> bus_req=0, host_ack=0, outstanding_o=4. A host write is accepted in the same condition. After head drains, the read is accepted one cycle later.
- Same-cycle tid reuse: slave responds tid 1 (data 0x11) and acks a new read with reqtid 1 in the same cycle -> old slot gets 0x11, a new pending slot is created with tid 1, err_o stays 0, and a later tid-1 response (0x22) is delivered after 0x11.
- Error: bus_resp with tid 2 while nothing is pending -> err_o=1 from the next cycle, held until rst_i. Assert rst_i asynchronously mid-burst -> outputs are 0 immediately and outstanding_o=0.
